// File: rtl/csa_mean_seq_if.sv
// Operand/result handshake bundle for the sequential carry-save mean unit.
// The operand source and result consumer sit on the master side; the unit
// itself sits on the slave side.
interface csa_mean_seq_if #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 15,
  parameter int REM_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] mean;
  logic [REM_W-1:0]  rem;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, mean, rem, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, mean, rem, busy
  );
endinterface

// File: rtl/csa_mean_seq.sv
// Sequential multi-operand mean unit: operands are folded into a carry-save
// pair one per handshake, the pair is resolved once per frame, and the total
// is divided by NUM_OPS with a bit-serial restoring divider (MSB first).
module csa_mean_seq #(
  parameter int DATA_W  = 8,
  parameter int NUM_OPS = 10,
  parameter int SUM_W   = 15,
  parameter int REM_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  csa_mean_seq_if.slave   bus
);

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] RESOLVE = 2'd1;
  localparam logic [1:0] DIVIDE  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int CNT_W = $clog2(NUM_OPS + 1);
  localparam int BIT_W = $clog2(SUM_W + 1);

  localparam logic [CNT_W-1:0] LAST_OP  = CNT_W'(NUM_OPS - 1);
  localparam logic [BIT_W-1:0] DIV_BITS = BIT_W'(SUM_W);
  localparam logic [REM_W:0]   DIVISOR  = (REM_W + 1)'(NUM_OPS);

  logic [1:0]        state;
  logic [SUM_W-1:0]  s;
  logic [SUM_W-1:0]  c;
  logic [CNT_W-1:0]  cnt;
  logic [SUM_W-1:0]  q;
  logic [REM_W:0]    r;
  logic [BIT_W-1:0]  bitcnt;
  logic [SUM_W-1:0]  sum_reg;
  logic [DATA_W-1:0] mean_reg;
  logic [REM_W-1:0]  rem_reg;

  logic [SUM_W-1:0]  x;
  logic [REM_W:0]    t;
  logic              qbit;
  logic [REM_W:0]    r_next;
  logic [SUM_W-1:0]  q_next;

  // 3:2 compressor sum output: bitwise parity of the three inputs.
  function automatic logic [SUM_W-1:0] csa_sum(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b,
                                               input logic [SUM_W-1:0] d);
    return a ^ b ^ d;
  endfunction

  // 3:2 compressor carry output: bitwise majority moved up one weight;
  // the carry out of the top bit is dropped since the frame total fits SUM_W.
  function automatic logic [SUM_W-1:0] csa_carry(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b,
                                                 input logic [SUM_W-1:0] d);
    return ((a & b) | (a & d) | (b & d)) << 1;
  endfunction

  // One restoring-division step on the current partial remainder and dividend MSB.
  always_comb begin
    x      = SUM_W'(bus.in_data);
    t      = {r[REM_W-1:0], q[SUM_W-1]};
    qbit   = (t >= DIVISOR);
    r_next = qbit ? (t - DIVISOR) : t;
    q_next = {q[SUM_W-2:0], qbit};
  end

  // Frame sequencing: accumulate, resolve, divide, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      s        <= '0;
      c        <= '0;
      cnt      <= '0;
      q        <= '0;
      r        <= '0;
      bitcnt   <= '0;
      sum_reg  <= '0;
      mean_reg <= '0;
      rem_reg  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            s   <= csa_sum(s, c, x);
            c   <= csa_carry(s, c, x);
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_OP) begin
              state <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          q       <= s + c;
          sum_reg <= s + c;
          r       <= '0;
          bitcnt  <= DIV_BITS;
          state   <= DIVIDE;
        end
        DIVIDE: begin
          q      <= q_next;
          r      <= r_next;
          bitcnt <= bitcnt - BIT_W'(1);
          // The quotient is bounded by 2^DATA_W-1, so only its low bits are kept.
          if (bitcnt == BIT_W'(1)) begin
            mean_reg <= q_next[DATA_W-1:0];
            rem_reg  <= r_next[REM_W-1:0];
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            s     <= '0;
            c     <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Handshake and status flags decode straight from the state register and rst.
  assign bus.in_ready  = !rst && (state == ACCUM);
  assign bus.out_valid = !rst && (state == DONE);
  assign bus.busy      = !rst && ((state == RESOLVE) || (state == DIVIDE));
  assign bus.sum       = sum_reg;
  assign bus.mean      = mean_reg;
  assign bus.rem       = rem_reg;

endmodule
